// File: rtl/rgb_led_pkg.sv
// Shared types and constants for the RGB LED controller.
// Holds the FSM state enum, cfg_addr map, control bit positions and the breathe ramp step.
package rgb_led_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ON     = 2'd2
    } led_state_t;

    localparam logic [1:0] ADDR_CH0  = 2'd0;
    localparam logic [1:0] ADDR_CH1  = 2'd1;
    localparam logic [1:0] ADDR_CH2  = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_BREATHE = 1;

    // Triangle ramp 0..255..0; returns {up_next, scale_next}.
    function automatic logic [8:0] breathe_step(
        input logic [7:0] scale,
        input logic       up
    );
        logic [8:0] r;
        if (up) begin
            if (scale == 8'hFF) r = {1'b0, 8'hFE};
            else                r = {1'b1, scale + 8'd1};
        end else begin
            if (scale == 8'h00) r = {1'b1, 8'h01};
            else                r = {1'b0, scale - 8'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/rgb_pwm_chan.sv
// One PWM channel: shadow/active duty pair plus registered comparator.
// Ports: clk, rst, wr_en/wr_data (duty write), run (state ON), wrap (counter
// rolls to 0 this edge), count (PWM counter), scale (RGB_BREATHE_EN only), pwm.
import rgb_led_pkg::*;

module rgb_pwm_chan #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [PWM_BITS-1:0] wr_data,
    input  logic                run,
    input  logic                wrap,
    input  logic [PWM_BITS-1:0] count,
`ifdef RGB_BREATHE_EN
    input  logic [7:0]          scale,
`endif
    output logic                pwm
);

    logic [PWM_BITS-1:0] shadow_q;
    logic [PWM_BITS-1:0] active_q;
    logic [PWM_BITS-1:0] eff_duty;
    logic [PWM_BITS-1:0] next_active;

`ifdef RGB_BREATHE_EN
    logic [PWM_BITS+7:0] prod;
    assign prod     = {8'd0, active_q} * {{PWM_BITS{1'b0}}, scale};
    assign eff_duty = PWM_BITS'(prod >> 8);
`else
    assign eff_duty = active_q;
`endif

    // A write landing on the same edge as the copy is forwarded so it is not lost.
    assign next_active = wr_en ? wr_data : shadow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
            pwm      <= 1'b0;
        end else begin
            if (wr_en)
                shadow_q <= wr_data;
            // Outside ON the duty follows writes at once; in ON only at period start.
            if (!run || wrap)
                active_q <= next_active;
            pwm <= run && (count < eff_duty);
        end
    end

endmodule

// File: rtl/rgb_led_ctrl.sv
// RGB LED driver controller: OFF -> SETTLE -> ON sequencing plus 3-channel PWM.
// Ports: clk, rst (async high), cfg_valid/cfg_ready/cfg_addr/cfg_data write port,
// curren, rgbleden, rgb_pwm[2:0], led_on. Optional breathe ramp: RGB_BREATHE_EN.
import rgb_led_pkg::*;

module rgb_led_ctrl #(
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE      = 4,
    parameter int SETTLE_CYCLES = 4800
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [1:0]          cfg_addr,
    input  logic [PWM_BITS-1:0] cfg_data,
    output logic                curren,
    output logic                rgbleden,
    output logic [2:0]          rgb_pwm,
    output logic                led_on
);

    localparam int SW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [PSW-1:0] PRE_LAST    = PSW'(PRESCALE - 1);

    led_state_t          state;
    logic [SW-1:0]       settle_cnt;
    logic [PSW-1:0]      pre_cnt;
    logic [PWM_BITS-1:0] count;
    logic [1:0]          ctrl_q;
    logic [2:0]          duty_we;

    logic wr_acc;
    logic ctrl_sel;
    logic en_wr;
    logic go_off;
    logic run;
    logic tick;
    logic wrap;

    assign wr_acc   = cfg_valid && cfg_ready;
    assign ctrl_sel = cfg_valid && (cfg_addr == ADDR_CTRL);
    assign en_wr    = wr_acc && ctrl_sel && cfg_data[CTRL_EN];

    // A disable during SETTLE aborts on cfg_valid alone; the write itself
    // then completes in OFF, where cfg_ready is high again.
    assign go_off = ctrl_sel && !cfg_data[CTRL_EN] &&
                    ((state == ST_SETTLE) || (state == ST_ON && cfg_ready));

    always_comb begin
        duty_we = '0;
        unique case (1'b1)
            (cfg_addr == ADDR_CH0): duty_we[0] = wr_acc;
            (cfg_addr == ADDR_CH1): duty_we[1] = wr_acc;
            (cfg_addr == ADDR_CH2): duty_we[2] = wr_acc;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ctrl_q <= '0;
        else if (wr_acc && cfg_addr == ADDR_CTRL)
            ctrl_q <= {cfg_data[CTRL_BREATHE], cfg_data[CTRL_EN]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_OFF;
            settle_cnt <= '0;
            curren     <= 1'b0;
            rgbleden   <= 1'b0;
            led_on     <= 1'b0;
            cfg_ready  <= 1'b0;
        end else begin
            unique case (state)
                ST_OFF: begin
                    cfg_ready <= 1'b1;
                    if (en_wr) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                        curren     <= 1'b1;
                        cfg_ready  <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (go_off) begin
                        state      <= ST_OFF;
                        settle_cnt <= '0;
                        curren     <= 1'b0;
                        cfg_ready  <= 1'b1;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state      <= ST_ON;
                        settle_cnt <= '0;
                        rgbleden   <= 1'b1;
                        led_on     <= 1'b1;
                        cfg_ready  <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                ST_ON: begin
                    if (go_off) begin
                        state    <= ST_OFF;
                        curren   <= 1'b0;
                        rgbleden <= 1'b0;
                        led_on   <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_OFF;
                    settle_cnt <= '0;
                    curren     <= 1'b0;
                    rgbleden   <= 1'b0;
                    led_on     <= 1'b0;
                    cfg_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Leaving ON takes effect on the disabling edge itself.
    assign run  = (state == ST_ON) && !go_off;
    assign tick = (pre_cnt == PRE_LAST);
    assign wrap = run && tick && (count == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            count   <= '0;
        end else if (!run) begin
            pre_cnt <= '0;
            count   <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            count   <= count + PWM_BITS'(1);
        end else begin
            pre_cnt <= pre_cnt + PSW'(1);
        end
    end

`ifdef RGB_BREATHE_EN
    logic [7:0] scale_q;
    logic       scale_up_q;
    logic [7:0] scale_eff;
    logic       ctrl_unused;

    assign ctrl_unused = ctrl_q[CTRL_EN];
    assign scale_eff   = ctrl_q[CTRL_BREATHE] ? scale_q : 8'hFF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scale_q    <= 8'd0;
            scale_up_q <= 1'b1;
        end else if (state != ST_ON) begin
            scale_q    <= 8'd0;
            scale_up_q <= 1'b1;
        end else if (wrap && ctrl_q[CTRL_BREATHE]) begin
            {scale_up_q, scale_q} <= breathe_step(scale_q, scale_up_q);
        end
    end
`else
    logic ctrl_unused;
    assign ctrl_unused = ^ctrl_q;
`endif

    for (genvar i = 0; i < 3; i++) begin : g_chan
        rgb_pwm_chan #(
            .PWM_BITS(PWM_BITS)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (duty_we[i]),
            .wr_data(cfg_data),
            .run    (run),
            .wrap   (wrap),
            .count  (count),
`ifdef RGB_BREATHE_EN
            .scale  (scale_eff),
`endif
            .pwm    (rgb_pwm[i])
        );
    end

endmodule
